// File: rtl/mcu_bus_master.sv
// Initiator for the 8-bit MCU<->FPGA parallel bus: one local read/write command
// becomes a full 4-phase mcu_mstr/fpga_ready transaction with timeout.
module mcu_bus_master #(
   parameter int SETUP_CYCLES   = 1,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       CLK50,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic [7:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       rsp_timeout,
   inout  wire  [7:0] data,
   output logic [7:0] address,
   output logic       mcu_mstr,
   output logic       write_enable,
   input  logic       fpga_ready
);

   localparam int CNT_MAX = (TIMEOUT_CYCLES > SETUP_CYCLES) ? TIMEOUT_CYCLES : SETUP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);
   localparam logic [CNT_W:0]   SETUP_N  = (CNT_W + 1)'(SETUP_CYCLES);
   localparam logic [CNT_W:0]   TMO_N    = (CNT_W + 1)'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_RELEASE,
      S_RESP
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt;
   logic [7:0]             r_addr;
   logic [7:0]             r_wdata;
   logic [7:0]             r_rdata;
   logic                   r_we;
   logic                   r_drive;
   logic                   r_mstr;
   logic                   r_timeout;

   logic                   w_rdy_s;
   logic [CNT_W:0]         w_elapsed;
   logic                   w_accept;
   logic                   w_capture;
   logic                   w_set_timeout;
   logic                   w_mstr_nxt;
   logic                   w_drive_nxt;

   assign w_rdy_s   = r_sync[SYNC_STAGES-1];
   // Cycles spent in the current state, including this one.
   assign w_elapsed = {1'b0, r_cnt} + (CNT_W + 1)'(1);
   assign w_accept  = (r_state == S_IDLE) && cmd_valid;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge CLK50 or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // NOTE: every combinational output gets a default first, so no path infers a latch.
   always_comb begin
      w_state_nxt   = r_state;
      w_capture     = 1'b0;
      w_set_timeout = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (cmd_valid) w_state_nxt = S_SETUP;
         end
         S_SETUP: begin
            if (w_rdy_s) begin
               if (w_elapsed >= TMO_N) begin
                  w_set_timeout = 1'b1;
                  w_state_nxt   = S_RELEASE;
               end
            end else if (w_elapsed >= SETUP_N) begin
               w_state_nxt = S_STROBE;
            end
         end
         S_STROBE: begin
            if (w_rdy_s) begin
               w_capture   = !r_we;
               w_state_nxt = S_RELEASE;
            end else if (w_elapsed >= TMO_N) begin
               w_set_timeout = 1'b1;
               w_state_nxt   = S_RELEASE;
            end
         end
         S_RELEASE: begin
            if (!w_rdy_s) begin
               w_state_nxt = S_RESP;
            end else if (w_elapsed >= TMO_N) begin
               w_set_timeout = 1'b1;
               w_state_nxt   = S_RESP;
            end
         end
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Bus strobe and driver enable are registered from the next state so the pins never glitch.
   always_comb begin
      cmd_ready   = (r_state == S_IDLE);
      rsp_valid   = (r_state == S_RESP);
      w_mstr_nxt  = (w_state_nxt == S_STROBE);
      w_drive_nxt = ((w_state_nxt == S_SETUP) || (w_state_nxt == S_STROBE)) &&
                    ((r_state == S_IDLE) ? cmd_write : r_we);
   end

   // NOTE: only control/bus registers carry a reset; none of this is memory, so all are cleared.
   always_ff @(posedge CLK50 or posedge rst) begin
      if (rst) begin
         r_sync    <= '0;
         r_cnt     <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_we      <= 1'b0;
         r_drive   <= 1'b0;
         r_mstr    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], fpga_ready};
         r_mstr  <= w_mstr_nxt;
         r_drive <= w_drive_nxt;

         if (w_state_nxt != r_state) r_cnt <= '0;
         else if (r_cnt != CNT_SAT)  r_cnt <= r_cnt + CNT_W'(1);

         if (w_accept) begin
            r_addr    <= cmd_addr;
            r_we      <= cmd_write;
            r_wdata   <= cmd_wdata;
            r_rdata   <= '0;
            r_timeout <= 1'b0;
         end else if (r_state == S_RESP) begin
            r_addr <= '0;
            r_we   <= 1'b0;
         end

         // Responder set data up before raising fpga_ready, so it is settled by the time rdy_s shows it.
         if (w_capture)     r_rdata   <= data;
         if (w_set_timeout) r_timeout <= 1'b1;
      end
   end

   assign data         = r_drive ? r_wdata : {8{1'bz}};
   assign address      = r_addr;
   assign write_enable = r_we;
   assign mcu_mstr     = r_mstr;
   assign rsp_rdata    = r_timeout ? 8'h00 : r_rdata;
   assign rsp_timeout  = r_timeout;

endmodule

// File: tb/tb_mcu_bus_master.sv
// Directed bench for mcu_bus_master: ideal, silent and stuck responders,
// back-to-back commands and reset in mid-transaction.
module tb_mcu_bus_master;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [7:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_timeout;
   wire  [7:0] data_bus;
   logic [7:0] address;
   logic       mcu_mstr;
   logic       write_enable;
   logic       fpga_ready = 1'b0;

   // Responder side of the data bus: probe value has priority, else read data = ~address.
   logic       probe_en;
   logic [7:0] probe_val;
   logic       auto_rsp;
   logic       tb_en;
   logic [7:0] tb_val;
   int         rmode;   // 0 ideal, 1 never ready, 2 ready stuck high

   int checks = 0;
   int errors = 0;
   int p      = 0;

   always #5 clk = ~clk;

   always_comb begin
      tb_en  = probe_en || (auto_rsp && !write_enable);
      tb_val = probe_en ? probe_val : ~address;
   end
   assign data_bus = tb_en ? tb_val : 8'bz;

   always @(negedge clk) begin
      case (rmode)
         0:       fpga_ready = mcu_mstr;
         1:       fpga_ready = 1'b0;
         default: fpga_ready = 1'b1;
      endcase
   end

   mcu_bus_master #(
      .SETUP_CYCLES  (1),
      .TIMEOUT_CYCLES(8),
      .SYNC_STAGES   (2)
   ) dut (
      .CLK50       (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_timeout (rsp_timeout),
      .data        (data_bus),
      .address     (address),
      .mcu_mstr    (mcu_mstr),
      .write_enable(write_enable),
      .fpga_ready  (fpga_ready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
      p++;
   endtask

   task automatic drive_cmd(input logic w, input logic [7:0] a, input logic [7:0] d);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at period %0d", p);
      $fatal(1, "watchdog");
   end

   logic [7:0] b_addr [4];
   logic       b_we   [4];
   logic [7:0] b_wd   [4];
   logic [7:0] b_rd   [4];

   initial begin
      int  mstr_cnt;
      int  rsp_cnt;
      int  idx;
      int  rsp_idx;
      int  rises;
      int  last_rsp;
      bit  got;
      bit  acc;
      logic prev_m;

      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = 8'h00;
      cmd_wdata = 8'h00;
      probe_en  = 1'b0;
      probe_val = 8'h00;
      auto_rsp  = 1'b1;
      rmode     = 0;
      tick();
      tick();

      // Reset state
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_timeout", rsp_timeout, 0);
      check("rst_address", address, 0);
      check("rst_mcu_mstr", mcu_mstr, 0);
      check("rst_write_enable", write_enable, 0);
      probe_en  = 1'b1;
      probe_val = 8'h5A;
      #1;
      check("rst_data_released", data_bus, 8'h5A);
      probe_en = 1'b0;
      rst = 1'b0;
      tick();
      tick();

      // 1: write 05/A5 with ideal responder
      drive_cmd(1'b1, 8'h05, 8'hA5);
      check("t1_ready_idle", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      cmd_wdata = 8'h00;
      for (int k = 1; k <= 9; k++) begin
         if (k > 1) tick();
         if (k == 5) begin
            probe_en  = 1'b1;
            probe_val = 8'h5A;
            #1;
         end
         check($sformatf("t1_mstr_%0d", k), mcu_mstr, (k >= 2 && k <= 4) ? 1 : 0);
         check($sformatf("t1_rsp_valid_%0d", k), rsp_valid, (k == 8) ? 1 : 0);
         check($sformatf("t1_cmd_ready_%0d", k), cmd_ready, (k == 9) ? 1 : 0);
         if (k >= 2 && k <= 4) begin
            check($sformatf("t1_addr_%0d", k), address, 8'h05);
            check($sformatf("t1_we_%0d", k), write_enable, 1);
            check($sformatf("t1_data_%0d", k), data_bus, 8'hA5);
         end
         if (k >= 5 && k <= 7) check($sformatf("t1_data_z_%0d", k), data_bus, 8'h5A);
         if (k == 8) begin
            check("t1_rsp_timeout", rsp_timeout, 0);
            check("t1_rsp_rdata", rsp_rdata, 0);
         end
         if (k == 9) begin
            check("t1_addr_idle", address, 0);
            check("t1_we_idle", write_enable, 0);
         end
      end
      probe_en = 1'b0;

      // 2: read 10, responder drives 3C
      probe_en  = 1'b1;
      probe_val = 8'h3C;
      drive_cmd(1'b0, 8'h10, 8'hFF);
      tick();
      cmd_valid = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         if (k > 1) tick();
         check($sformatf("t2_data_%0d", k), data_bus, 8'h3C);
         check($sformatf("t2_mstr_%0d", k), mcu_mstr, (k >= 2 && k <= 4) ? 1 : 0);
         check($sformatf("t2_rsp_valid_%0d", k), rsp_valid, (k == 8) ? 1 : 0);
         if (k >= 2 && k <= 4) begin
            check($sformatf("t2_addr_%0d", k), address, 8'h10);
            check($sformatf("t2_we_%0d", k), write_enable, 0);
         end
         if (k == 8) begin
            check("t2_rsp_rdata", rsp_rdata, 8'h3C);
            check("t2_rsp_timeout", rsp_timeout, 0);
         end
      end
      probe_en = 1'b0;

      // 3: responder never ready -> 8 strobe cycles then timeout
      rmode     = 1;
      probe_en  = 1'b1;
      probe_val = 8'h77;
      drive_cmd(1'b0, 8'h22, 8'h00);
      tick();
      cmd_valid = 1'b0;
      mstr_cnt  = 0;
      for (int k = 1; k <= 12; k++) begin
         if (k > 1) tick();
         mstr_cnt += int'(mcu_mstr);
         check($sformatf("t3_rsp_valid_%0d", k), rsp_valid, (k == 11) ? 1 : 0);
         if (k == 11) begin
            check("t3_rsp_timeout", rsp_timeout, 1);
            check("t3_rsp_rdata", rsp_rdata, 0);
         end
      end
      check("t3_mstr_cycles", mstr_cnt, 8);
      check("t3_back_idle", cmd_ready, 1);
      probe_en = 1'b0;
      rmode    = 0;
      repeat (3) tick();

      // 4: ready stuck high at accept -> no strobe, timeout response
      rmode = 2;
      repeat (4) tick();
      drive_cmd(1'b0, 8'h44, 8'h00);
      tick();
      cmd_valid = 1'b0;
      mstr_cnt  = 0;
      got       = 1'b0;
      for (int k = 0; k < 60; k++) begin
         mstr_cnt += int'(mcu_mstr);
         if (rsp_valid) begin
            got = 1'b1;
            check("t4_rsp_timeout", rsp_timeout, 1);
            check("t4_rsp_rdata", rsp_rdata, 0);
            break;
         end
         tick();
      end
      check("t4_rsp_seen", got, 1);
      check("t4_mstr_cycles", mstr_cnt, 0);
      rmode = 0;
      repeat (4) tick();
      check("t4_back_idle", cmd_ready, 1);

      // 5: four back-to-back commands with cmd_valid held
      b_addr = '{8'h30, 8'h31, 8'h32, 8'h33};
      b_we   = '{1'b1, 1'b0, 1'b1, 1'b0};
      b_wd   = '{8'h11, 8'h00, 8'h22, 8'h00};
      b_rd   = '{8'h00, 8'hCE, 8'h00, 8'hCC};
      idx      = 0;
      rsp_idx  = 0;
      rises    = 0;
      last_rsp = 0;
      prev_m   = 1'b0;
      drive_cmd(b_we[0], b_addr[0], b_wd[0]);
      for (int k = 0; k < 80 && rsp_idx < 4; k++) begin
         acc = cmd_ready && cmd_valid;
         tick();
         if (acc) begin
            idx++;
            if (idx < 4) drive_cmd(b_we[idx], b_addr[idx], b_wd[idx]);
            else         cmd_valid = 1'b0;
         end
         check($sformatf("t5_ready_busy_%0d", k), cmd_ready && (mcu_mstr || rsp_valid), 0);
         if (mcu_mstr && !prev_m) rises++;
         prev_m = mcu_mstr;
         if (mcu_mstr) begin
            check($sformatf("t5_addr_%0d", k), address, b_addr[rsp_idx]);
            if (write_enable) check($sformatf("t5_wdata_%0d", k), data_bus, b_wd[rsp_idx]);
         end
         if (rsp_valid) begin
            check($sformatf("t5_rdata_%0d", rsp_idx), rsp_rdata, b_rd[rsp_idx]);
            check($sformatf("t5_timeout_%0d", rsp_idx), rsp_timeout, 0);
            check($sformatf("t5_strobes_%0d", rsp_idx), rises, 1);
            if (rsp_idx > 0) check($sformatf("t5_spacing_%0d", rsp_idx), k - last_rsp, 9);
            last_rsp = k;
            rsp_idx++;
            rises = 0;
         end
      end
      check("t5_rsp_count", rsp_idx, 4);
      cmd_valid = 1'b0;
      repeat (2) tick();

      // 6: reset asserted during STROBE
      drive_cmd(1'b1, 8'h66, 8'h99);
      tick();
      cmd_valid = 1'b0;
      tick();
      check("t6_in_strobe", mcu_mstr, 1);
      rst = 1'b1;
      #1;
      check("t6_mstr_low", mcu_mstr, 0);
      check("t6_cmd_ready", cmd_ready, 1);
      check("t6_address", address, 0);
      check("t6_we", write_enable, 0);
      check("t6_rsp_valid", rsp_valid, 0);
      probe_en  = 1'b1;
      probe_val = 8'h5A;
      #1;
      check("t6_data_released", data_bus, 8'h5A);
      probe_en = 1'b0;
      tick();
      tick();
      rst     = 1'b0;
      rsp_cnt = 0;
      repeat (12) begin
         tick();
         rsp_cnt += int'(rsp_valid);
      end
      check("t6_no_response", rsp_cnt, 0);
      check("t6_idle_ready", cmd_ready, 1);
      check("t6_idle_mstr", mcu_mstr, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
